// File: rtl/fnd_display_scheduler.sv
// Chooses the time word and page shown on the 4-digit FND: watch, stopwatch or a timed alert.
// Latency: all outputs registered, 1 cycle from inputs; no backpressure, alert uses a req/ack handshake.
module fnd_display_scheduler #(
  parameter int unsigned TICK_DIV = 100_000,
  parameter int unsigned PAGE_MS  = 3000,
  parameter int unsigned ALERT_MS = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode,
  input  logic        auto_en,
  input  logic        btn_page,
  input  logic [23:0] watch_time,
  input  logic [23:0] sw_time,
  input  logic        alert_req,
  input  logic [23:0] alert_data,
  output logic        alert_ack,
  output logic [23:0] fnd_in_data,
  output logic        sel_display,
  output logic [1:0]  active_src
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (PAGE_MS  > 1) ? $clog2(PAGE_MS)  : 1;
  localparam int AW = (ALERT_MS > 1) ? $clog2(ALERT_MS) : 1;

  typedef enum logic [1:0] {
    ST_WATCH = 2'b00,
    ST_SW    = 2'b01,
    ST_ALERT = 2'b10
  } state_t;

  state_t        state_q, state_d;
  state_t        prev_q, prev_d;
  state_t        mode_st;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [PW-1:0] page_cnt_q, page_cnt_d;
  logic [AW-1:0] alert_cnt_q, alert_cnt_d;
  logic          rearm_q, rearm_d;
  logic [23:0]   fnd_q, fnd_d;
  logic          sel_q, sel_d;
  logic          ack_q, ack_d;
  logic [1:0]    src_q, src_d;
  logic          tick;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  assign mode_st    = mode ? ST_SW : ST_WATCH;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    page_cnt_d  = page_cnt_q;
    alert_cnt_d = alert_cnt_q;
    rearm_d     = rearm_q | ~alert_req;
    sel_d       = sel_q;
    ack_d       = 1'b0;
    fnd_d       = watch_time;
    src_d       = 2'b00;

    case (state_q)
      ST_WATCH, ST_SW: begin
        // Alert entry beats a simultaneous mode change; rearm blocks a held req.
        if (alert_req && rearm_q) begin
          state_d     = ST_ALERT;
          prev_d      = state_q;
          rearm_d     = 1'b0;
          alert_cnt_d = '0;
        end else if (mode_st != state_q) begin
          state_d    = mode_st;
          sel_d      = (mode_st == ST_WATCH);
          page_cnt_d = '0;
        end else if (btn_page) begin
          sel_d      = ~sel_q;
          page_cnt_d = '0;
        end else if (state_q == ST_WATCH && auto_en) begin
          if (tick) begin
            if (page_cnt_q == PW'(PAGE_MS - 1)) begin
              sel_d      = ~sel_q;
              page_cnt_d = '0;
            end else begin
              page_cnt_d = page_cnt_q + 1'b1;
            end
          end
        end else begin
          page_cnt_d = '0;
        end
      end
      ST_ALERT: begin
        if (!alert_req || (tick && alert_cnt_q == AW'(ALERT_MS - 1))) begin
          ack_d       = alert_req;
          state_d     = mode_st;
          alert_cnt_d = '0;
          // Entry rules apply only when the mode moved while the alert was up.
          if (mode_st != prev_q) begin
            sel_d      = (mode_st == ST_WATCH);
            page_cnt_d = '0;
          end
        end else if (tick) begin
          alert_cnt_d = alert_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_WATCH;
    endcase

    case (state_d)
      ST_ALERT: begin fnd_d = alert_data; src_d = 2'b10; end
      ST_SW:    begin fnd_d = sw_time;    src_d = 2'b01; end
      default:  begin fnd_d = watch_time; src_d = 2'b00; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_WATCH;
      prev_q      <= ST_WATCH;
      tick_cnt_q  <= '0;
      page_cnt_q  <= '0;
      alert_cnt_q <= '0;
      rearm_q     <= 1'b1;
      fnd_q       <= '0;
      sel_q       <= 1'b1;
      ack_q       <= 1'b0;
      src_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      tick_cnt_q  <= tick_cnt_d;
      page_cnt_q  <= page_cnt_d;
      alert_cnt_q <= alert_cnt_d;
      rearm_q     <= rearm_d;
      fnd_q       <= fnd_d;
      sel_q       <= sel_d;
      ack_q       <= ack_d;
      src_q       <= src_d;
    end
  end

  assign fnd_in_data = fnd_q;
  assign sel_display = sel_q;
  assign alert_ack   = ack_q;
  assign active_src  = src_q;

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Directed bench for fnd_display_scheduler with a 4-clk ms tick, 3-ms pages and 5-ms alerts.
module tb_fnd_display_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic        auto_en;
  logic        btn_page;
  logic [23:0] watch_time;
  logic [23:0] sw_time;
  logic        alert_req;
  logic [23:0] alert_data;
  logic        alert_ack;
  logic [23:0] fnd_in_data;
  logic        sel_display;
  logic [1:0]  active_src;

  int n_vec = 0;
  int n_bad = 0;
  int edges = 0;

  fnd_display_scheduler #(.TICK_DIV(4), .PAGE_MS(3), .ALERT_MS(5)) dut (
    .clk(clk), .reset(reset), .mode(mode), .auto_en(auto_en), .btn_page(btn_page),
    .watch_time(watch_time), .sw_time(sw_time), .alert_req(alert_req),
    .alert_data(alert_data), .alert_ack(alert_ack), .fnd_in_data(fnd_in_data),
    .sel_display(sel_display), .active_src(active_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Returns cycles until sel_display changes, or -1 if it never does.
  task automatic wait_sel_change(output int n);
    logic old;
    old = sel_display;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (sel_display !== old) begin
        n = i;
        break;
      end
    end
  endtask

  // Returns cycles until alert_ack is seen high, or -1 if it never is.
  task automatic wait_ack(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (alert_ack === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    int cnt2;
    reset = 1'b0; mode = 1'b0; auto_en = 1'b0; btn_page = 1'b0; alert_req = 1'b0;
    watch_time = 24'h0A5A3C; sw_time = 24'h031B2C; alert_data = 24'h173B63;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fnd", 32'(fnd_in_data), 32'h0);
    chk("rst_sel", 32'(sel_display), 32'h1);
    chk("rst_src", 32'(active_src), 32'h0);
    chk("rst_ack", 32'(alert_ack), 32'h0);

    // 1: first cycle after release shows the watch time
    reset = 1'b1;
    edges = 0;
    step();
    chk("t1_fnd", 32'(fnd_in_data), 32'h0A5A3C);
    chk("t1_sel", 32'(sel_display), 32'h1);
    chk("t1_src", 32'(active_src), 32'h0);

    // 2: auto paging every 12 clk, button restarts the page
    auto_en = 1'b1;
    wait_sel_change(n);
    chk("t2_first_toggle", 32'(n > 0), 32'h1);
    wait_sel_change(n);
    chk("t2_period", 32'(n), 32'd12);
    chk("t2_sel", 32'(sel_display), 32'h1);
    repeat (7) step();
    btn_page = 1'b1;
    step();
    btn_page = 1'b0;
    chk("t2_btn_sel", 32'(sel_display), 32'h0);
    wait_sel_change(n);
    chk("t2_restart", 32'(n), 32'd12);
    chk("t2_fnd", 32'(fnd_in_data), 32'h0A5A3C);

    // 3: stopwatch page, no auto paging, button still toggles
    mode = 1'b1;
    step();
    chk("t3_sel", 32'(sel_display), 32'h0);
    chk("t3_fnd", 32'(fnd_in_data), 32'h031B2C);
    chk("t3_src", 32'(active_src), 32'h1);
    cnt = 0;
    repeat (30) begin
      step();
      if (sel_display !== 1'b0) cnt++;
    end
    chk("t3_no_autopage", 32'(cnt), 32'd0);
    btn_page = 1'b1;
    step();
    btn_page = 1'b0;
    chk("t3_btn", 32'(sel_display), 32'h1);

    // 4: alert from stopwatch, entry aligned on a tick edge
    while (edges % 4 != 3) step();
    alert_req = 1'b1;
    step();
    chk("t4_src", 32'(active_src), 32'h2);
    chk("t4_fnd", 32'(fnd_in_data), 32'h173B63);
    chk("t4_sel_held", 32'(sel_display), 32'h1);
    wait_ack(n);
    chk("t4_ack_lat", 32'(n), 32'd20);
    chk("t4_ret_src", 32'(active_src), 32'h1);
    chk("t4_ret_fnd", 32'(fnd_in_data), 32'h031B2C);
    chk("t4_ret_sel", 32'(sel_display), 32'h1);
    step();
    chk("t4_ack_pulse", 32'(alert_ack), 32'h0);
    cnt = 0; cnt2 = 0;
    repeat (30) begin
      step();
      if (alert_ack === 1'b1) cnt++;
      if (active_src === 2'b10) cnt2++;
    end
    chk("t4_held_req_ack", 32'(cnt), 32'd0);
    chk("t4_no_reenter", 32'(cnt2), 32'd0);
    alert_req = 1'b0;
    step();
    alert_req = 1'b1;
    step();
    chk("t4_rearm", 32'(active_src), 32'h2);
    alert_req = 1'b0;
    step();
    chk("t4_abort_src", 32'(active_src), 32'h1);
    chk("t4_abort_ack", 32'(alert_ack), 32'h0);

    // 5: alert beats a simultaneous mode change; later abort after 2 ticks
    auto_en = 1'b0;
    mode = 1'b0;
    step();
    chk("t5_watch_src", 32'(active_src), 32'h0);
    chk("t5_watch_sel", 32'(sel_display), 32'h1);
    alert_req = 1'b1;
    mode = 1'b1;
    step();
    chk("t5_alert_first", 32'(active_src), 32'h2);
    chk("t5_alert_sel", 32'(sel_display), 32'h1);
    wait_ack(n);
    chk("t5_ack_seen", 32'(n > 0), 32'h1);
    chk("t5_exit_src", 32'(active_src), 32'h1);
    chk("t5_exit_sel", 32'(sel_display), 32'h0);
    alert_req = 1'b0;
    step();
    alert_req = 1'b1;
    step();
    chk("t5_reenter", 32'(active_src), 32'h2);
    cnt = 0;
    repeat (8) begin
      step();
      if (alert_ack === 1'b1) cnt++;
    end
    alert_req = 1'b0;
    step();
    chk("t5_abort_src", 32'(active_src), 32'h1);
    repeat (30) begin
      step();
      if (alert_ack === 1'b1) cnt++;
    end
    chk("t5_abort_no_ack", 32'(cnt), 32'd0);

    // 6: reset asserted mid-alert clears outputs without an edge
    alert_req = 1'b1;
    step();
    chk("t6_alert", 32'(active_src), 32'h2);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("t6_fnd", 32'(fnd_in_data), 32'h0);
    chk("t6_sel", 32'(sel_display), 32'h1);
    chk("t6_src", 32'(active_src), 32'h0);
    chk("t6_ack", 32'(alert_ack), 32'h0);
    cnt = 0;
    repeat (25) begin
      step();
      if (alert_ack === 1'b1) cnt++;
    end
    chk("t6_no_ack_in_reset", 32'(cnt), 32'd0);
    alert_req = 1'b0;
    reset = 1'b1;
    step();
    chk("t6_post_src", 32'(active_src), 32'h1);
    chk("t6_post_sel", 32'(sel_display), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
